// File: rtl/ult_pkg.sv
// ult_pkg: shared types and defaults for the ultrasonic distance filter.
//   state_t       - filter FSM states
//   ECHO_W/DIST_W - echo tick-count and distance widths
//   DEF_*         - default conversion / saturation / hysteresis constants
package ult_pkg;

  localparam int ECHO_W = 20;
  localparam int DIST_W = 10;

  localparam logic [11:0]       DEF_TICKS_PER_CM = 12'd2900;
  localparam logic [DIST_W-1:0] DEF_MAX_CM       = 10'd400;
  localparam logic [DIST_W-1:0] DEF_NEAR_ON_CM   = 10'd20;
  localparam logic [DIST_W-1:0] DEF_NEAR_OFF_CM  = 10'd25;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    FILTER = 2'd2,
    OUTPUT = 2'd3
  } state_t;

endpackage

// File: rtl/ult_seq_divider.sv
// ult_seq_divider: restoring divider, one quotient bit per clock, fixed
// 20-iteration latency, saturating quotient.
//   clk, rst_n  - clock, async active-low reset
//   start       - load dividend and begin (ignored while running)
//   dividend    - 20-bit dividend
//   divisor     - 12-bit divisor (must be non-zero)
//   max_q       - saturation limit for the quotient
//   done        - high during the final iteration; quotient is valid from
//                 the following cycle until the next start
//   quotient    - saturated quotient
module ult_seq_divider
  import ult_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ECHO_W-1:0] dividend,
  input  logic [11:0]       divisor,
  input  logic [DIST_W-1:0] max_q,
  output logic              done,
  output logic [DIST_W-1:0] quotient
);

  logic [ECHO_W-1:0] q;
  logic [11:0]       rem;
  logic [4:0]        count;
  logic              active;
  logic [12:0]       rem_sh;
  logic              fits;

  // q doubles as the shift register: dividend bits leave at the top while
  // quotient bits enter at the bottom.
  assign rem_sh = {rem, q[ECHO_W-1]};
  assign fits   = rem_sh >= {1'b0, divisor};
  assign done   = active && (count == 5'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q      <= '0;
      rem    <= '0;
      count  <= '0;
      active <= 1'b0;
    end else if (!active) begin
      if (start) begin
        q      <= dividend;
        rem    <= '0;
        count  <= 5'(ECHO_W);
        active <= 1'b1;
      end
    end else begin
      if (fits) begin
        rem <= 12'(rem_sh - {1'b0, divisor});
      end else begin
        rem <= rem_sh[11:0];
      end
      q     <= {q[ECHO_W-2:0], fits};
      count <= count - 5'd1;
      if (count == 5'd1) begin
        active <= 1'b0;
      end
    end
  end

  assign quotient = (q > {10'd0, max_q}) ? max_q : q[DIST_W-1:0];

endmodule

// File: rtl/ult_distance_filter.sv
// ult_distance_filter: converts echo pulse widths to centimetres, averages
// the last 4 samples and drives a presence flag with hysteresis.
//   clk, rst_n    - clock, async active-low reset
//   echo_count    - echo width in clk ticks, taken with echo_valid
//   echo_valid    - strobe: new measurement (wins over echo_timeout)
//   echo_timeout  - strobe: no echo, treated as a MAX_CM sample
//   dist_cm       - averaged distance, held between updates
//   dist_valid    - one-cycle pulse when dist_cm/near update
//   near          - presence flag with hysteresis
//   busy          - sample in flight
//   overrun       - sticky: strobe dropped while busy
//
// state  | meaning
// IDLE   | waiting for a strobe
// DIVIDE | divider converting ticks to cm (20 cycles)
// FILTER | window/sum update, new distance and near computed
// OUTPUT | dist_valid pulse, new dist_cm/near visible
module ult_distance_filter
  import ult_pkg::*;
#(
  parameter logic [11:0]       TICKS_PER_CM = DEF_TICKS_PER_CM,
  parameter logic [DIST_W-1:0] MAX_CM       = DEF_MAX_CM,
  parameter logic [DIST_W-1:0] NEAR_ON_CM   = DEF_NEAR_ON_CM,
  parameter logic [DIST_W-1:0] NEAR_OFF_CM  = DEF_NEAR_OFF_CM,
  parameter int                AVG_LOG2     = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ECHO_W-1:0] echo_count,
  input  logic              echo_valid,
  input  logic              echo_timeout,
  output logic [DIST_W-1:0] dist_cm,
  output logic              dist_valid,
  output logic              near,
  output logic              busy,
  output logic              overrun
);

  localparam int DEPTH = 1 << AVG_LOG2;

  localparam logic [1:0] S_IDLE   = 2'(IDLE);
  localparam logic [1:0] S_DIVIDE = 2'(DIVIDE);
  localparam logic [1:0] S_FILTER = 2'(FILTER);
  localparam logic [1:0] S_OUTPUT = 2'(OUTPUT);

  logic [1:0]          state;
  logic                from_tmo;
  logic                prime;
  logic [DIST_W-1:0]   win [DEPTH];
  logic [AVG_LOG2-1:0] wr_ptr;
  logic [11:0]         sum;

  logic                div_start;
  logic                div_done;
  logic [DIST_W-1:0]   div_q;
  logic [DIST_W-1:0]   sample;
  logic [11:0]         sum_next;
  logic [DIST_W-1:0]   dist_next;
  logic                near_next;

  assign div_start = (state == S_IDLE) && echo_valid;

  ult_seq_divider u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (echo_count),
    .divisor  (TICKS_PER_CM),
    .max_q    (MAX_CM),
    .done     (div_done),
    .quotient (div_q)
  );

  assign sample = from_tmo ? MAX_CM : div_q;

  always_comb begin
    sum_next = sum;
    if (prime) begin
      sum_next = {2'b00, sample} << AVG_LOG2;
    end else begin
      sum_next = sum - {2'b00, win[wr_ptr]} + {2'b00, sample};
    end
    dist_next = DIST_W'(sum_next >> AVG_LOG2);

    near_next = near;
    if (!near && (dist_next < NEAR_ON_CM)) begin
      near_next = 1'b1;
    end else if (near && (dist_next > NEAR_OFF_CM)) begin
      near_next = 1'b0;
    end
  end

  // dist_cm/near are registered on the FILTER->OUTPUT edge so they are
  // already current while dist_valid is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      from_tmo <= 1'b0;
      prime    <= 1'b1;
      wr_ptr   <= '0;
      sum      <= '0;
      dist_cm  <= '0;
      near     <= 1'b0;
      overrun  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        win[i] <= '0;
      end
    end else begin
      if (busy && (echo_valid || echo_timeout)) begin
        overrun <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (echo_valid) begin
            from_tmo <= 1'b0;
            state    <= S_DIVIDE;
          end else if (echo_timeout) begin
            from_tmo <= 1'b1;
            state    <= S_FILTER;
          end
        end
        S_DIVIDE: begin
          if (div_done) begin
            state <= S_FILTER;
          end
        end
        S_FILTER: begin
          sum     <= sum_next;
          dist_cm <= dist_next;
          near    <= near_next;
          if (prime) begin
            for (int i = 0; i < DEPTH; i++) begin
              win[i] <= sample;
            end
            prime <= 1'b0;
          end else begin
            win[wr_ptr] <= sample;
            wr_ptr      <= wr_ptr + 1'b1;
          end
          state <= S_OUTPUT;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy       = (state != S_IDLE);
  assign dist_valid = (state == S_OUTPUT);

endmodule
